// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front end of the KGP-RISC datapath. It owns the program counter, issues
// word reads to instruction memory over a req/ack handshake, holds each
// returned instruction in an output register for the decoder, and reacts to
// taken branch/jump redirects by squashing whatever is on the wrong path.
//
// Ports:
//   clk_i            system clock, all state changes on the rising edge
//   rst_i            asynchronous active-high reset
//   imem_req_o       read request to instruction memory
//   imem_addr_o      word-aligned byte address of the request
//   imem_ack_i       memory returns imem_rdata_i for the outstanding request
//   imem_rdata_i     instruction word, only looked at when imem_ack_i = 1
//   stall_i          downstream cannot take the held instruction this cycle
//   redirect_valid_i one-cycle pulse: resume fetching at redirect_pc_i
//   redirect_pc_i    redirect target (low two bits are ignored)
//   instr_valid_o    instr_o / opcode_o / instr_pc_o are valid
//   instr_o          held instruction word
//   opcode_o         instr_o[31:26], feeds main_control
//   instr_pc_o       address the held instruction was fetched from
//   fetch_count_o    number of instructions handed downstream
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [5:0]  opcode_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] fetch_count_o
);

  // S_DRAIN exists so a request that is already on the bus is always allowed
  // to finish (and its data thrown away) before the redirect target goes out.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetchState_e;

  fetchState_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drainAddr_q, drainAddr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instrPc_q, instrPc_d;
  logic [31:0] fetchCount_q, fetchCount_d;
  logic [31:0] redirectTarget;
  logic [31:0] pcAligned;
  logic        unusedRedirectLowBits;

  // Redirect targets are forced onto a word boundary; the dropped low bits
  // are folded into a dummy signal so they are visibly consumed.
  assign redirectTarget        = {redirect_pc_i[31:2], 2'b00};
  assign unusedRedirectLowBits = ^redirect_pc_i[1:0];
  assign pcAligned             = {pc_q[31:2], 2'b00};

  // State register plus every piece of held state. Reset is asynchronous so
  // a reset in the middle of a memory transaction takes effect at once; the
  // memory side is expected to tolerate the abandoned request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drainAddr_q  <= RESET_PC;
      instr_q      <= 32'h0000_0000;
      instrPc_q    <= 32'h0000_0000;
      fetchCount_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drainAddr_q  <= drainAddr_d;
      instr_q      <= instr_d;
      instrPc_q    <= instrPc_d;
      fetchCount_q <= fetchCount_d;
    end
  end

  // Next-state logic. A redirect outranks both ack and stall in every state.
  // In S_FETCH without an ack the request is already visible to memory, so
  // the old address is parked in drainAddr_q and we wait in S_DRAIN for the
  // ack rather than changing the address mid-handshake. With an ack in the
  // same cycle the returned word belongs to the wrong path and is dropped.
  // In S_HOLD a redirect kills the held instruction without counting it.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drainAddr_d  = drainAddr_q;
    instr_d      = instr_q;
    instrPc_d    = instrPc_q;
    fetchCount_d = fetchCount_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (redirect_valid_i) begin
          pc_d = redirectTarget;
        end
      end

      S_FETCH: begin
        if (redirect_valid_i) begin
          pc_d = redirectTarget;
          if (!imem_ack_i) begin
            drainAddr_d = pcAligned;
            state_d     = S_DRAIN;
          end
        end else if (imem_ack_i) begin
          instr_d   = imem_rdata_i;
          instrPc_d = pcAligned;
          pc_d      = pc_q + PC_STEP;
          state_d   = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect_valid_i) begin
          pc_d    = redirectTarget;
          state_d = S_FETCH;
        end else if (!stall_i) begin
          fetchCount_d = fetchCount_q + 32'd1;
          state_d      = S_FETCH;
        end
      end

      S_DRAIN: begin
        if (redirect_valid_i) begin
          pc_d = redirectTarget;
        end
        if (imem_ack_i) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory-side outputs depend only on registered state so that neither
  // stall_i nor imem_ack_i can reach imem_req_o / imem_addr_o combinationally.
  always_comb begin
    imem_req_o  = (state_q == S_FETCH) || (state_q == S_DRAIN);
    imem_addr_o = (state_q == S_DRAIN) ? drainAddr_q : pcAligned;
  end

  // Decoder-side outputs are straight views of the held registers.
  always_comb begin
    instr_valid_o = (state_q == S_HOLD);
    instr_o       = instr_q;
    opcode_o      = instr_q[31:26];
    instr_pc_o    = instrPc_q;
    fetch_count_o = fetchCount_q;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Bench for instruction_fetch_unit. A behavioural instruction memory with a
// programmable ack latency answers requests; each scenario task pushes the
// instructions it expects to see onto a scoreboard queue, and a monitor pops
// and compares them as the unit presents new instructions.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } expT;

  logic        clk;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        stall;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        instrValid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instrPc;
  logic [31:0] fetchCount;

  logic [31:0] memWords [128];
  int          memLatency;
  logic        memOff;
  int          waitCnt;

  expT         expectQ [$];
  logic [31:0] ackAddrs [$];
  int          ackLens [$];
  int          presentedCount;
  int          stableErrors;
  int          compareCount;
  int          mismatchCount;

  instruction_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (32'd4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .imem_req_o      (imemReq),
    .imem_addr_o     (imemAddr),
    .imem_ack_i      (imemAck),
    .imem_rdata_i    (imemRdata),
    .stall_i         (stall),
    .redirect_valid_i(redirectValid),
    .redirect_pc_i   (redirectPc),
    .instr_valid_o   (instrValid),
    .instr_o         (instr),
    .opcode_o        (opcode),
    .instr_pc_o      (instrPc),
    .fetch_count_o   (fetchCount)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: ack comes on the memLatency-th cycle of a request,
  // so memLatency = 1 behaves like a zero-wait memory with ack tied to req.
  assign imemAck   = imemReq && !memOff && (waitCnt >= memLatency - 1);
  assign imemRdata = memWords[imemAddr[8:2]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) waitCnt <= 0;
    else if (imemReq && imemAck) waitCnt <= 0;
    else if (imemReq) waitCnt <= waitCnt + 1;
  end

  // Monitor: pops the scoreboard whenever a new instruction appears, logs
  // every acked address with the length of its request, and counts any
  // address change while a request is waiting for its ack.
  initial begin : monitor
    logic        prevValid;
    logic        pendActive;
    logic [31:0] pendAddr;
    int          reqLen;
    expT         e;
    prevValid  = 1'b0;
    pendActive = 1'b0;
    pendAddr   = 32'h0;
    reqLen     = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevValid  = 1'b0;
        pendActive = 1'b0;
        reqLen     = 0;
      end else begin
        if (instrValid && !prevValid) begin
          presentedCount++;
          compareCount++;
          if (expectQ.size() == 0) begin
            mismatchCount++;
            $display("[TB] FAIL scoreboard_unexpected: got pc=%h instr=%h, required no instruction", instrPc, instr);
          end else begin
            e = expectQ.pop_front();
            if (instr !== e.word || instrPc !== e.pc || opcode !== e.word[31:26]) begin
              mismatchCount++;
              $display("[TB] FAIL scoreboard: got pc=%h instr=%h opcode=%b, required pc=%h instr=%h opcode=%b",
                       instrPc, instr, opcode, e.pc, e.word, e.word[31:26]);
            end
          end
        end
        prevValid = instrValid;
        if (imemReq) begin
          if (pendActive && imemAddr !== pendAddr) stableErrors++;
          reqLen++;
          if (imemAck) begin
            ackAddrs.push_back(imemAddr);
            ackLens.push_back(reqLen);
            reqLen     = 0;
            pendActive = 1'b0;
          end else begin
            pendActive = 1'b1;
            pendAddr   = imemAddr;
          end
        end
      end
    end
  end

  // Step to just after the next falling edge, well away from the rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset(input int latency);
    rst           = 1'b1;
    stall         = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
    memOff        = 1'b0;
    memLatency    = latency;
    tick();
    tick();
    expectQ.delete();
    ackAddrs.delete();
    ackLens.delete();
    stableErrors = 0;
    rst          = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    compareCount++; if (imemReq !== 1'b0) begin mismatchCount++; $display("[TB] FAIL reset_req: got %b, required 0", imemReq); end
    compareCount++; if (imemAddr !== 32'h0) begin mismatchCount++; $display("[TB] FAIL reset_addr: got %h, required 0", imemAddr); end
    compareCount++; if (instrValid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL reset_valid: got %b, required 0", instrValid); end
    compareCount++; if (instr !== 32'h0) begin mismatchCount++; $display("[TB] FAIL reset_instr: got %h, required 0", instr); end
    compareCount++; if (opcode !== 6'h0) begin mismatchCount++; $display("[TB] FAIL reset_opcode: got %b, required 0", opcode); end
    compareCount++; if (instrPc !== 32'h0) begin mismatchCount++; $display("[TB] FAIL reset_instr_pc: got %h, required 0", instrPc); end
    compareCount++; if (fetchCount !== 32'h0) begin mismatchCount++; $display("[TB] FAIL reset_count: got %0d, required 0", fetchCount); end
  endtask

  task automatic test_zero_wait();
    memWords[0] = 32'h0400_0001;
    memWords[1] = 32'h0800_0002;
    doReset(1);
    expectQ.push_back('{pc: 32'h0, word: 32'h0400_0001});
    expectQ.push_back('{pc: 32'h4, word: 32'h0800_0002});
    tick();
    compareCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin mismatchCount++; $display("[TB] FAIL zw_req0: got req=%b addr=%h, required 1/0", imemReq, imemAddr); end
    compareCount++; if (instrValid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL zw_valid_c1: got %b, required 0", instrValid); end
    tick();
    compareCount++; if (instrValid !== 1'b1 || opcode !== 6'b000001) begin mismatchCount++; $display("[TB] FAIL zw_op1: got valid=%b op=%b, required 1/000001", instrValid, opcode); end
    tick();
    compareCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h4 || instrValid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL zw_req4: got req=%b addr=%h valid=%b, required 1/4/0", imemReq, imemAddr, instrValid); end
    tick();
    compareCount++; if (instrValid !== 1'b1 || opcode !== 6'b000010) begin mismatchCount++; $display("[TB] FAIL zw_op2: got valid=%b op=%b, required 1/000010", instrValid, opcode); end
    memOff = 1'b1;
    tick();
    compareCount++; if (imemAddr !== 32'h8 || imemReq !== 1'b1) begin mismatchCount++; $display("[TB] FAIL zw_req8: got req=%b addr=%h, required 1/8", imemReq, imemAddr); end
    compareCount++; if (fetchCount !== 32'd2) begin mismatchCount++; $display("[TB] FAIL zw_count: got %0d, required 2", fetchCount); end
    compareCount++; if (expectQ.size() != 0) begin mismatchCount++; $display("[TB] FAIL zw_drained: got %0d left, required 0", expectQ.size()); end
  endtask

  task automatic test_latency();
    doReset(3);
    expectQ.push_back('{pc: 32'h0, word: memWords[0]});
    expectQ.push_back('{pc: 32'h4, word: memWords[1]});
    for (int i = 0; i < 20 && presentedCount < 2; i++) tick();
    for (int i = 0; i < 20 && ackAddrs.size() < 2; i++) tick();
    for (int i = 0; i < 20 && !instrValid; i++) tick();
    compareCount++; if (!instrValid) begin mismatchCount++; $display("[TB] FAIL lat_timeout: got valid=0, required 1"); end
    memOff = 1'b1;
    tick();
    compareCount++; if (ackAddrs.size() != 2) begin mismatchCount++; $display("[TB] FAIL lat_ack_count: got %0d, required 2", ackAddrs.size()); end
    else begin
      compareCount++; if (ackAddrs[0] !== 32'h0 || ackAddrs[1] !== 32'h4) begin mismatchCount++; $display("[TB] FAIL lat_addrs: got %h,%h, required 0,4", ackAddrs[0], ackAddrs[1]); end
      compareCount++; if (ackLens[0] != 3 || ackLens[1] != 3) begin mismatchCount++; $display("[TB] FAIL lat_req_len: got %0d,%0d, required 3,3", ackLens[0], ackLens[1]); end
    end
    compareCount++; if (stableErrors != 0) begin mismatchCount++; $display("[TB] FAIL lat_addr_stable: got %0d changes, required 0", stableErrors); end
    compareCount++; if (expectQ.size() != 0) begin mismatchCount++; $display("[TB] FAIL lat_drained: got %0d left, required 0", expectQ.size()); end
  endtask

  task automatic test_stall();
    memWords[0] = 32'hF000_0ABC;
    doReset(1);
    stall = 1'b1;
    expectQ.push_back('{pc: 32'h0, word: 32'hF000_0ABC});
    tick();
    tick();
    compareCount++; if (instrValid !== 1'b1) begin mismatchCount++; $display("[TB] FAIL stall_valid: got %b, required 1", instrValid); end
    for (int i = 0; i < 5; i++) begin
      tick();
      compareCount++;
      if (instrValid !== 1'b1 || instr !== 32'hF000_0ABC || opcode !== 6'b111100 ||
          instrPc !== 32'h0 || imemReq !== 1'b0 || fetchCount !== 32'd0) begin
        mismatchCount++;
        $display("[TB] FAIL stall_hold%0d: got valid=%b instr=%h op=%b pc=%h req=%b cnt=%0d, required 1/f0000abc/111100/0/0/0",
                 i, instrValid, instr, opcode, instrPc, imemReq, fetchCount);
      end
    end
    stall  = 1'b0;
    memOff = 1'b1;
    tick();
    compareCount++; if (fetchCount !== 32'd1) begin mismatchCount++; $display("[TB] FAIL stall_release_count: got %0d, required 1", fetchCount); end
    compareCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h4) begin mismatchCount++; $display("[TB] FAIL stall_release_addr: got req=%b addr=%h, required 1/4", imemReq, imemAddr); end
    compareCount++; if (expectQ.size() != 0) begin mismatchCount++; $display("[TB] FAIL stall_drained: got %0d left, required 0", expectQ.size()); end
  endtask

  task automatic test_redirect_drain();
    doReset(2);
    expectQ.push_back('{pc: 32'h0, word: memWords[0]});
    expectQ.push_back('{pc: 32'h4, word: memWords[1]});
    expectQ.push_back('{pc: 32'h100, word: memWords[64]});
    for (int i = 0; i < 20 && !(imemReq && imemAddr == 32'h8); i++) tick();
    compareCount++; if (!(imemReq && imemAddr == 32'h8)) begin mismatchCount++; $display("[TB] FAIL rd_reach8: got req=%b addr=%h, required 1/8", imemReq, imemAddr); end
    redirectValid = 1'b1;
    redirectPc    = 32'h0000_0103;
    tick();
    redirectValid = 1'b0;
    compareCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h8 || instrValid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL rd_drain: got req=%b addr=%h valid=%b, required 1/8/0", imemReq, imemAddr, instrValid); end
    for (int i = 0; i < 10 && !(imemReq && imemAddr != 32'h8); i++) tick();
    compareCount++; if (imemAddr !== 32'h100 || imemReq !== 1'b1) begin mismatchCount++; $display("[TB] FAIL rd_next_addr: got req=%b addr=%h, required 1/100", imemReq, imemAddr); end
    for (int i = 0; i < 10 && !instrValid; i++) tick();
    compareCount++; if (instrValid !== 1'b1 || instrPc !== 32'h100) begin mismatchCount++; $display("[TB] FAIL rd_target_pc: got valid=%b pc=%h, required 1/100", instrValid, instrPc); end
    memOff = 1'b1;
    tick();
    compareCount++; if (ackAddrs.size() != 4) begin mismatchCount++; $display("[TB] FAIL rd_ack_count: got %0d, required 4", ackAddrs.size()); end
    else begin
      compareCount++; if (ackAddrs[2] !== 32'h8 || ackAddrs[3] !== 32'h100) begin mismatchCount++; $display("[TB] FAIL rd_ack_seq: got %h,%h, required 8,100", ackAddrs[2], ackAddrs[3]); end
    end
    compareCount++; if (stableErrors != 0) begin mismatchCount++; $display("[TB] FAIL rd_addr_stable: got %0d changes, required 0", stableErrors); end
    compareCount++; if (expectQ.size() != 0) begin mismatchCount++; $display("[TB] FAIL rd_drained: got %0d left, required 0", expectQ.size()); end
  endtask

  task automatic test_redirect_hold();
    memWords[0]  = 32'hFC00_0011;
    memWords[16] = 32'h1234_5678;
    memWords[32] = 32'h0C00_0080;
    doReset(1);
    expectQ.push_back('{pc: 32'h0,  word: 32'hFC00_0011});
    expectQ.push_back('{pc: 32'h40, word: 32'h1234_5678});
    expectQ.push_back('{pc: 32'h80, word: 32'h0C00_0080});
    tick();
    tick();
    compareCount++; if (instrValid !== 1'b1 || opcode !== 6'b111111) begin mismatchCount++; $display("[TB] FAIL rh_hold_op: got valid=%b op=%b, required 1/111111", instrValid, opcode); end
    redirectValid = 1'b1;
    redirectPc    = 32'h0000_0040;
    tick();
    redirectValid = 1'b0;
    compareCount++; if (instrValid !== 1'b0 || fetchCount !== 32'd0) begin mismatchCount++; $display("[TB] FAIL rh_squash: got valid=%b cnt=%0d, required 0/0", instrValid, fetchCount); end
    compareCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h40) begin mismatchCount++; $display("[TB] FAIL rh_target_addr: got req=%b addr=%h, required 1/40", imemReq, imemAddr); end
    tick();
    tick();
    compareCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h44 || fetchCount !== 32'd1) begin mismatchCount++; $display("[TB] FAIL rh_seq_44: got req=%b addr=%h cnt=%0d, required 1/44/1", imemReq, imemAddr, fetchCount); end
    redirectValid = 1'b1;
    redirectPc    = 32'h0000_0080;
    tick();
    redirectValid = 1'b0;
    compareCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h80 || instrValid !== 1'b0) begin mismatchCount++; $display("[TB] FAIL rh_ack_discard: got req=%b addr=%h valid=%b, required 1/80/0", imemReq, imemAddr, instrValid); end
    tick();
    compareCount++; if (instrValid !== 1'b1 || instrPc !== 32'h80) begin mismatchCount++; $display("[TB] FAIL rh_final_pc: got valid=%b pc=%h, required 1/80", instrValid, instrPc); end
    memOff = 1'b1;
    tick();
    compareCount++; if (fetchCount !== 32'd2) begin mismatchCount++; $display("[TB] FAIL rh_count: got %0d, required 2", fetchCount); end
    compareCount++; if (expectQ.size() != 0) begin mismatchCount++; $display("[TB] FAIL rh_drained: got %0d left, required 0", expectQ.size()); end
  endtask

  task automatic test_async_reset();
    doReset(3);
    expectQ.push_back('{pc: 32'h0, word: memWords[0]});
    for (int i = 0; i < 20 && !instrValid; i++) tick();
    tick();
    compareCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h4 || fetchCount !== 32'd1) begin mismatchCount++; $display("[TB] FAIL ar_midreq: got req=%b addr=%h cnt=%0d, required 1/4/1", imemReq, imemAddr, fetchCount); end
    #1 rst = 1'b1;
    #1;
    compareCount++;
    if (imemReq !== 1'b0 || imemAddr !== 32'h0 || instrValid !== 1'b0 || instr !== 32'h0 ||
        opcode !== 6'h0 || instrPc !== 32'h0 || fetchCount !== 32'h0) begin
      mismatchCount++;
      $display("[TB] FAIL ar_immediate: got req=%b addr=%h valid=%b instr=%h op=%b pc=%h cnt=%0d, required all zero",
               imemReq, imemAddr, instrValid, instr, opcode, instrPc, fetchCount);
    end
    tick();
    expectQ.delete();
    expectQ.push_back('{pc: 32'h0, word: memWords[0]});
    rst = 1'b0;
    tick();
    compareCount++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin mismatchCount++; $display("[TB] FAIL ar_restart: got req=%b addr=%h, required 1/0", imemReq, imemAddr); end
    for (int i = 0; i < 20 && !instrValid; i++) tick();
    compareCount++; if (instrValid !== 1'b1 || instrPc !== 32'h0) begin mismatchCount++; $display("[TB] FAIL ar_refetch: got valid=%b pc=%h, required 1/0", instrValid, instrPc); end
    memOff = 1'b1;
    tick();
    compareCount++; if (expectQ.size() != 0) begin mismatchCount++; $display("[TB] FAIL ar_drained: got %0d left, required 0", expectQ.size()); end
  endtask

  // Hard stop in case something wedges the scenario sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compareCount   = 0;
    mismatchCount  = 0;
    presentedCount = 0;
    stableErrors   = 0;
    memOff         = 1'b0;
    memLatency     = 1;
    rst            = 1'b1;
    stall          = 1'b0;
    redirectValid  = 1'b0;
    redirectPc     = 32'h0;
    for (int i = 0; i < 128; i++) memWords[i] = {6'(i + 1), 26'(i + 1)};

    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_drain();
    test_redirect_hold();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
